everloop_ws_serializer: RTL and testbench

- Downstream stage of the everloop LED RAM. Reads LED bytes through the read port (adr_b/dat_b) of the dual-port RAM, which is written by the Wishbone side.
- Drives a single-wire NRZ stream (WS2812/SK6812 timing) onto led_ctl.
- Refreshes the LED ring continuously: one frame, then a latch gap, then the next frame.

---
 rtl/everloop_pkg.sv | 28 ++
 rtl/everloop_ws_serializer_bit_gen.sv | 63 ++++++
 rtl/everloop_ws_serializer.sv | 142 ++++++++++++++
 tb/tb_everloop_ws_serializer.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/everloop_pkg.sv
// Shared types and defaults for the everloop WS2812/SK6812 serializer.
package everloop_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2,
        ST_LATCH = 2'd3
    } state_t;

    // Default timing at 150 MHz: 1.25 us bit, 0.35/0.70 us high times, 80 us latch.
    localparam int DEF_N_LEDS        = 35;
    localparam int DEF_BYTES_PER_LED = 4;
    localparam int DEF_ADR_WIDTH     = 11;
    localparam int DEF_TBIT_CYC      = 188;
    localparam int DEF_T0H_CYC       = 53;
    localparam int DEF_T1H_CYC       = 105;
    localparam int DEF_TRESET_CYC    = 12000;

    // Index of the bit within a byte, 7 down to 0.
    localparam int BIT_IDX_W = 3;

    // Width of a counter that runs 0..n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/everloop_ws_serializer_bit_gen.sv
// Single NRZ bit period generator: one high/low waveform per start strobe.
module ws_bit_gen
    import everloop_pkg::*;
#(
    parameter int TBIT_CYC = DEF_TBIT_CYC,
    parameter int T0H_CYC  = DEF_T0H_CYC,
    parameter int T1H_CYC  = DEF_T1H_CYC
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic bit_val,
    output logic bit_done,
    output logic led
);

    localparam int CW = cnt_width(TBIT_CYC);
    localparam logic [CW-1:0] CNT_LAST = CW'(TBIT_CYC - 1);
    localparam logic [CW-1:0] T0H_L    = CW'(T0H_CYC);
    localparam logic [CW-1:0] T1H_L    = CW'(T1H_CYC);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          active_q, active_d;
    logic          led_q, led_d;

    // Counts through one bit period; a start on the final count chains the next bit with no gap.
    always_comb begin
        cnt_d    = cnt_q;
        active_d = active_q;
        led_d    = 1'b0;
        bit_done = 1'b0;
        if (active_q) begin
            led_d = (cnt_q < (bit_val ? T1H_L : T0H_L));
            if (cnt_q == CNT_LAST) begin
                bit_done = 1'b1;
                active_d = 1'b0;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        if (start) begin
            active_d = 1'b1;
            cnt_d    = '0;
        end
    end

    // Counter and registered line output; reset forces the line low immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
            led_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
            led_q    <= led_d;
        end
    end

    assign led = led_q;

endmodule

// File: rtl/everloop_ws_serializer.sv
// Everloop LED ring refresher: reads LED bytes from the RAM read port and streams them as WS2812 NRZ.
module everloop_ws_serializer
    import everloop_pkg::*;
#(
    parameter int N_LEDS        = DEF_N_LEDS,
    parameter int BYTES_PER_LED = DEF_BYTES_PER_LED,
    parameter int ADR_WIDTH     = DEF_ADR_WIDTH,
    parameter int TBIT_CYC      = DEF_TBIT_CYC,
    parameter int T0H_CYC       = DEF_T0H_CYC,
    parameter int T1H_CYC       = DEF_T1H_CYC,
    parameter int TRESET_CYC    = DEF_TRESET_CYC
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    output logic [ADR_WIDTH-1:0] ram_adr,
    input  logic [7:0]           ram_dat,
    output logic                 led_ctl,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int N_BYTES = N_LEDS * BYTES_PER_LED;
    localparam int LW      = cnt_width(TRESET_CYC);
    localparam logic [LW-1:0]        LATCH_LAST = LW'(TRESET_CYC - 1);
    // During byte b the address already points at b+1, so this value marks the final byte.
    localparam logic [ADR_WIDTH-1:0] LAST_ADR   = ADR_WIDTH'(N_BYTES);

    if (!((0 < T0H_CYC) && (T0H_CYC < T1H_CYC) && (T1H_CYC < TBIT_CYC))) begin : g_bad_timing
        $error("everloop_ws_serializer: need 0 < T0H_CYC < T1H_CYC < TBIT_CYC");
    end
    if (N_BYTES > (1 << ADR_WIDTH)) begin : g_bad_size
        $error("everloop_ws_serializer: LED bytes do not fit the RAM address space");
    end

    state_t                 state_q, state_d;
    logic                   fetch_phase_q, fetch_phase_d;
    logic [7:0]             shreg_q, shreg_d;
    logic [BIT_IDX_W-1:0]   bit_idx_q, bit_idx_d;
    logic [ADR_WIDTH-1:0]   ram_adr_q, ram_adr_d;
    logic [LW-1:0]          latch_cnt_q, latch_cnt_d;
    logic                   bit_start;
    logic                   bit_done;

    ws_bit_gen #(
        .TBIT_CYC (TBIT_CYC),
        .T0H_CYC  (T0H_CYC),
        .T1H_CYC  (T1H_CYC)
    ) u_bit_gen (
        .clk      (clk),
        .reset    (reset),
        .start    (bit_start),
        .bit_val  (shreg_q[7]),
        .bit_done (bit_done),
        .led      (led_ctl)
    );

    // Frame sequencing: fetch byte 0, shift bits MSB first, reload from the prefetched address, then latch.
    always_comb begin
        state_d       = state_q;
        fetch_phase_d = fetch_phase_q;
        shreg_d       = shreg_q;
        bit_idx_d     = bit_idx_q;
        ram_adr_d     = ram_adr_q;
        latch_cnt_d   = latch_cnt_q;
        bit_start     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ram_adr_d = '0;
                if (enable) begin
                    state_d       = ST_FETCH;
                    fetch_phase_d = 1'b0;
                end
            end
            ST_FETCH: begin
                if (!fetch_phase_q) begin
                    fetch_phase_d = 1'b1;
                end else begin
                    fetch_phase_d = 1'b0;
                    shreg_d       = ram_dat;
                    bit_idx_d     = 3'd7;
                    ram_adr_d     = ram_adr_q + ADR_WIDTH'(1);
                    bit_start     = 1'b1;
                    state_d       = ST_SEND;
                end
            end
            ST_SEND: begin
                if (bit_done) begin
                    if (bit_idx_q != 3'd0) begin
                        shreg_d   = {shreg_q[6:0], 1'b0};
                        bit_idx_d = bit_idx_q - 3'd1;
                        bit_start = 1'b1;
                    end else if (ram_adr_q != LAST_ADR) begin
                        shreg_d   = ram_dat;
                        bit_idx_d = 3'd7;
                        ram_adr_d = ram_adr_q + ADR_WIDTH'(1);
                        bit_start = 1'b1;
                    end else begin
                        state_d     = ST_LATCH;
                        latch_cnt_d = '0;
                    end
                end
            end
            ST_LATCH: begin
                if (latch_cnt_q == LATCH_LAST) begin
                    latch_cnt_d = '0;
                    ram_adr_d   = '0;
                    state_d     = enable ? ST_FETCH : ST_IDLE;
                end else begin
                    latch_cnt_d = latch_cnt_q + LW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, shift register, address and latch counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            fetch_phase_q <= 1'b0;
            shreg_q       <= '0;
            bit_idx_q     <= '0;
            ram_adr_q     <= '0;
            latch_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            fetch_phase_q <= fetch_phase_d;
            shreg_q       <= shreg_d;
            bit_idx_q     <= bit_idx_d;
            ram_adr_q     <= ram_adr_d;
            latch_cnt_q   <= latch_cnt_d;
        end
    end

    assign ram_adr    = ram_adr_q;
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = (state_q == ST_LATCH) && (latch_cnt_q == LATCH_LAST);

endmodule

// File: tb/tb_everloop_ws_serializer.sv
// Testbench for everloop_ws_serializer: decodes the NRZ line and scores bytes against a queue.
module tb_everloop_ws_serializer;

    localparam int N_LEDS    = 2;
    localparam int BPL       = 4;
    localparam int ADR_W     = 11;
    localparam int TBIT      = 10;
    localparam int T0H       = 3;
    localparam int T1H       = 6;
    localparam int TRST      = 20;
    localparam int NBYTES    = N_LEDS * BPL;
    localparam int FRAME_CYC = 2 + NBYTES * 8 * TBIT + TRST;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             enable = 1'b0;
    logic [ADR_W-1:0] ram_adr;
    logic [7:0]       ram_dat;
    logic             led_ctl;
    logic             busy;
    logic             frame_done;

    everloop_ws_serializer #(
        .N_LEDS        (N_LEDS),
        .BYTES_PER_LED (BPL),
        .ADR_WIDTH     (ADR_W),
        .TBIT_CYC      (TBIT),
        .T0H_CYC       (T0H),
        .T1H_CYC       (T1H),
        .TRESET_CYC    (TRST)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .ram_adr    (ram_adr),
        .ram_dat    (ram_dat),
        .led_ctl    (led_ctl),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // RAM read port model with one cycle of registered read latency.
    logic [7:0] mem [0:(1<<ADR_W)-1];
    always @(posedge clk) ram_dat <= mem[ram_adr];

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_vec++;
        if (actual != expected) begin
            n_err++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, actual, actual, expected, expected, cyc);
        end
    endtask

    // Line decoder state.
    logic prev_led = 1'b0;
    int   run_len = 0;
    int   last_high = 0;
    int   nbits = 0;
    int   frame_bits = 0;
    logic [7:0] byte_acc = 8'h00;
    bit   rise_armed = 1'b0;
    int   first_rise_cyc = -1;
    int   prev_adr = 0;
    int   adr_max = 0;
    int   adr_bad = 0;

    // Decode high/low run lengths on the falling clock edge and score every bit and byte.
    always @(negedge clk) begin
        if (reset) begin
            prev_led   = led_ctl;
            run_len    = 0;
            nbits      = 0;
            frame_bits = 0;
            byte_acc   = 8'h00;
            prev_adr   = int'(ram_adr);
        end else begin
            if (led_ctl !== prev_led) begin
                if (prev_led) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected_bit", 1, 0);
                    end else begin
                        logic [7:0] eb;
                        eb = exp_q[0];
                        checkOutput("high_width", run_len, eb[7 - nbits] ? T1H : T0H);
                    end
                    byte_acc = {byte_acc[6:0], (run_len > (T0H + T1H) / 2) ? 1'b1 : 1'b0};
                    last_high = run_len;
                    nbits++;
                    frame_bits++;
                    if (nbits == 8) begin
                        if (exp_q.size() != 0) begin
                            logic [7:0] eb2;
                            eb2 = exp_q.pop_front();
                            checkOutput("byte_value", int'(byte_acc), int'(eb2));
                        end
                        nbits = 0;
                    end
                    if (frame_bits == NBYTES * 8) frame_bits = 0;
                end else begin
                    if (frame_bits != 0) checkOutput("low_width", run_len, TBIT - last_high);
                    if (rise_armed) begin
                        first_rise_cyc = cyc;
                        rise_armed     = 1'b0;
                    end
                end
                prev_led = led_ctl;
                run_len  = 1;
            end else begin
                run_len++;
            end
            if (int'(ram_adr) != prev_adr) begin
                if (int'(ram_adr) != prev_adr + 1 && ram_adr != '0) adr_bad = 1;
            end
            if (int'(ram_adr) > adr_max) adr_max = int'(ram_adr);
            prev_adr = int'(ram_adr);
        end
    end

    typedef struct {
        string       name;
        logic [63:0] data;
        int          exp_latency;
        int          exp_done_ofs;
    } vec_t;

    vec_t vecs [4];
    int   busy_low_cnt = 0;

    task automatic applyStimulus(input logic [63:0] load, input logic [63:0] expect_d);
        for (int b = 0; b < NBYTES; b++) begin
            mem[b] = load[63 - 8*b -: 8];
            exp_q.push_back(expect_d[63 - 8*b -: 8]);
        end
    endtask

    task automatic startFrame(output int e0);
        @(posedge clk);
        #1;
        enable     = 1'b1;
        e0         = cyc + 1;
        adr_max    = 0;
        adr_bad    = 0;
        rise_armed = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic waitFrameDone(output int dc);
        dc = -1;
        for (int i = 0; i < 3 * FRAME_CYC && dc < 0; i++) begin
            @(negedge clk);
            if (!busy) busy_low_cnt++;
            if (frame_done) dc = cyc;
        end
        if (dc < 0) checkOutput("frame_done_timeout", 0, 1);
    endtask

    task automatic waitBits(input int nb, input bit need_high);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3 * FRAME_CYC && !ok; i++) begin
            @(negedge clk);
            if (frame_bits >= nb && (!need_high || led_ctl)) ok = 1'b1;
        end
        if (!ok) checkOutput("wait_bits_timeout", 0, 1);
    endtask

    task automatic finishFrame(input int e0, input int exp_lat, input int exp_ofs);
        int dc;
        waitFrameDone(dc);
        if (dc >= 0) checkOutput("frame_done_offset", dc - e0, exp_ofs);
        checkOutput("first_high_latency", first_rise_cyc - e0, exp_lat);
        checkOutput("ram_adr_max", adr_max, NBYTES);
        checkOutput("ram_adr_step_err", adr_bad, 0);
        checkOutput("bytes_outstanding", exp_q.size(), 0);
    endtask

    task automatic checkIdleAfter();
        @(posedge clk);
        @(negedge clk);
        checkOutput("idle_busy", int'(busy), 0);
        checkOutput("idle_led", int'(led_ctl), 0);
        checkOutput("idle_adr", int'(ram_adr), 0);
    endtask

    initial begin
        int e0;
        int d1;
        int d2;

        for (int i = 0; i < (1 << ADR_W); i++) mem[i] = 8'h00;
        vecs[0] = '{"mixed",  64'hA5_00_FF_01_80_7E_C3_3C, 3, FRAME_CYC - 1};
        vecs[1] = '{"all_ff", 64'hFF_FF_FF_FF_FF_FF_FF_FF, 3, FRAME_CYC - 1};
        vecs[2] = '{"all_00", 64'h00_00_00_00_00_00_00_00, 3, FRAME_CYC - 1};
        vecs[3] = '{"walk",   64'h01_02_04_08_10_20_40_80, 3, FRAME_CYC - 1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_led", int'(led_ctl), 0);
        checkOutput("reset_adr", int'(ram_adr), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_frame_done", int'(frame_done), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("idle_no_enable_busy", int'(busy), 0);

        // Single frames from the vector table.
        for (int v = 0; v < 4; v++) begin
            $display("[TB] vector %s", vecs[v].name);
            applyStimulus(vecs[v].data, vecs[v].data);
            startFrame(e0);
            enable = 1'b0;
            finishFrame(e0, vecs[v].exp_latency, vecs[v].exp_done_ofs);
            checkIdleAfter();
        end

        // Continuous refresh: second FETCH starts right after frame_done.
        $display("[TB] continuous refresh");
        applyStimulus(vecs[0].data, vecs[0].data);
        applyStimulus(vecs[0].data, vecs[0].data);
        busy_low_cnt = 0;
        startFrame(e0);
        waitFrameDone(d1);
        rise_armed = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("refresh_busy", int'(busy), 1);
        enable = 1'b0;
        waitFrameDone(d2);
        checkOutput("frame_period", d2 - d1, FRAME_CYC);
        checkOutput("refresh_first_high", first_rise_cyc - d1, 4);
        checkOutput("busy_low_during_refresh", busy_low_cnt, 0);
        checkOutput("refresh_bytes_outstanding", exp_q.size(), 0);
        checkIdleAfter();

        // Enable dropped at bit 20 still completes the frame and latch gap.
        $display("[TB] enable drop mid-frame");
        applyStimulus(vecs[3].data, vecs[3].data);
        startFrame(e0);
        waitBits(20, 1'b0);
        #1 enable = 1'b0;
        finishFrame(e0, 3, FRAME_CYC - 1);
        checkIdleAfter();
        repeat (30) @(posedge clk);
        @(negedge clk);
        checkOutput("stays_idle_busy", int'(busy), 0);
        checkOutput("stays_idle_led", int'(led_ctl), 0);

        // Reset while the line is high mid-bit, then a clean restart from byte 0.
        $display("[TB] reset mid-bit");
        applyStimulus(vecs[0].data, vecs[0].data);
        startFrame(e0);
        waitBits(12, 1'b1);
        #2 reset = 1'b1;
        #1;
        checkOutput("rst_led_async", int'(led_ctl), 0);
        checkOutput("rst_busy_async", int'(busy), 0);
        checkOutput("rst_adr_async", int'(ram_adr), 0);
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        applyStimulus(vecs[0].data, vecs[0].data);
        adr_max    = 0;
        adr_bad    = 0;
        rise_armed = 1'b1;
        reset      = 1'b0;
        e0         = cyc + 1;
        @(posedge clk);
        #1 enable = 1'b0;
        finishFrame(e0, 3, FRAME_CYC - 1);
        checkIdleAfter();

        // RAM byte 3 rewritten while byte 1 is on the line.
        $display("[TB] RAM rewrite during frame");
        applyStimulus(vecs[0].data, 64'hA5_00_FF_80_80_7E_C3_3C);
        startFrame(e0);
        enable = 1'b0;
        waitBits(10, 1'b0);
        mem[3] = 8'h80;
        finishFrame(e0, 3, FRAME_CYC - 1);
        checkIdleAfter();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
